// File: rtl/ps2_key_buffer.sv
// PS/2 keyboard receiver feeding a scan-code FIFO for the memory-mapped keyboard port.
// Optional macro PS2_BREAK_FILTER_EN drops F0 break prefixes and the byte that follows them.
module ps2_key_buffer #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       resetp,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clean_key_buffer,
  output logic [7:0] pressed_key,
  output logic       keyboard_valid,
  output logic       key_overflow,
  output logic       frame_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3} rx_state_t;

  logic            clk_s1_q, clk_s2_q, clk_prev_q, fall_q;
  logic            dat_s1_q, dat_s2_q;
  rx_state_t       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            push_s, err_s, push_en_s;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            popped_q, popped_d;
  logic [7:0]      pressed_key_q, pressed_key_d;
  logic            valid_q, valid_d, overflow_q, overflow_d, frame_error_q;
  logic            full_s, pop_s, push_ok_s;

  // Synchronizers idle high; fall_q is a registered falling-edge strobe of the PS/2 clock
  always_ff @(posedge CLK or posedge resetp) begin
    if (resetp) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      fall_q     <= clk_prev_q & ~clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // Frame decoder next state, including the partial-frame timeout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    push_s    = 1'b0;
    err_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_q && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (fall_q) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (fall_q) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (fall_q) begin
          if (dat_s2_q && ((^shift_q) ^ par_q)) begin
            push_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_IDLE || fall_q) begin
      tmo_d = {TW{1'b0}};
    end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
      tmo_d   = {TW{1'b0}};
      state_d = S_IDLE;
      err_s   = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Decoder state registers
  always_ff @(posedge CLK or posedge resetp) begin
    if (resetp) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      par_q         <= 1'b0;
      tmo_q         <= {TW{1'b0}};
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      tmo_q         <= tmo_d;
      frame_error_q <= err_s;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic skip_q, skip_d;

  // Break filter: swallow F0 and the key code that follows it
  always_comb begin
    skip_d    = skip_q;
    push_en_s = 1'b0;
    if (push_s) begin
      if (shift_q == 8'hF0) begin
        skip_d = 1'b1;
      end else if (skip_q) begin
        skip_d = 1'b0;
      end else begin
        push_en_s = 1'b1;
      end
    end else begin
      push_en_s = 1'b0;
    end
  end

  // Break filter flag
  always_ff @(posedge CLK or posedge resetp) begin
    if (resetp) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
    end
  end
`else
  assign push_en_s = push_s;
`endif

  // FIFO bookkeeping; the head byte is precomputed so pressed_key is a flop
  always_comb begin
    full_s     = (count_q == CW'(DEPTH));
    pop_s      = clean_key_buffer & valid_q & ~popped_q;
    push_ok_s  = push_en_s & (~full_s | pop_s);
    overflow_d = overflow_q | (push_en_s & full_s & ~pop_s);
    wr_ptr_d   = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (!clean_key_buffer) begin
      popped_d = 1'b0;
    end else if (pop_s) begin
      popped_d = 1'b1;
    end else begin
      popped_d = popped_q;
    end
    valid_d = (count_d != CW'(0));
    if (!valid_d) begin
      pressed_key_d = 8'h00;
    end else if (push_ok_s && rd_ptr_d == wr_ptr_q) begin
      pressed_key_d = shift_q;
    end else begin
      pressed_key_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO control and output registers
  always_ff @(posedge CLK or posedge resetp) begin
    if (resetp) begin
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {CW{1'b0}};
      popped_q      <= 1'b0;
      pressed_key_q <= 8'h00;
      valid_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      popped_q      <= popped_d;
      pressed_key_q <= pressed_key_d;
      valid_q       <= valid_d;
      overflow_q    <= overflow_d;
    end
  end

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign pressed_key    = pressed_key_q;
  assign keyboard_valid = valid_q;
  assign key_overflow   = overflow_q;
  assign frame_error    = frame_error_q;

endmodule

// File: doc/ps2_key_buffer.md
# ps2_key_buffer

PS/2 keyboard receiver and scan-code FIFO, directly upstream of the memory subsystem's keyboard port at address 0xFFFFFFFF. It oversamples the keyboard's PS/2 clock/data lines and decodes 11-bit frames with parity and stop checks. Valid bytes are queued and the head entry is presented on `pressed_key`/`keyboard_valid`. The memory subsystem's `clean_key_buffer` strobe consumes one entry per CPU read.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `TIMEOUT_CYCLES`, 50000: CLK cycles without a PS/2 falling edge before a partial frame is abandoned; minimum 16.
- `CLK` input 1: CPU clock; all logic on its rising edge.
- `resetp` input 1: one clock; reset is asynchronous and active-high.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `clean_key_buffer` input 1: pop request from the memory subsystem; may be held for several cycles.
- `pressed_key` output 8: FIFO head byte; 8'h00 when empty.
- `keyboard_valid` output 1: FIFO non-empty.
- `key_overflow` output 1: sticky; a byte was dropped because the FIFO was full.
- `frame_error` output 1: one-cycle pulse on a parity or stop-bit failure, or on a timeout.

## Operation
- **Synchronizer:** each pin passes through a 2-FF synchronizer. The synchronized clock is registered once more, so a falling edge is `prev & ~cur` (the `fall` strobe). Data is sampled from the synchronized `ps2_data` in the `fall` cycle.
- **Receiver FSM states:**
  - IDLE: on `fall` with data=0 go to DATA, bit count 0. On `fall` with data=1 stay in IDLE; this is not an error.
  - DATA: 8 `fall` events shift data LSB-first into the shift register, then go to PARITY.
  - PARITY: on `fall` store the bit, go to STOP.
  - STOP: on `fall` check stop=1 and odd parity (XOR of 8 data bits and the parity bit == 1). Pass: issue a push strobe for the byte. Fail: pulse `frame_error`, no push. Either way return to IDLE.
- **Timeout:** a cycle counter is cleared on every `fall` and whenever the FSM is in IDLE. In DATA, PARITY or STOP, reaching TIMEOUT_CYCLES returns the FSM to IDLE and pulses `frame_error` in that cycle.
- **FIFO:** circular buffer with read/write pointers of log2(DEPTH) bits (wrapping modulo DEPTH) and a count of log2(DEPTH)+1 bits.
  - Push when not full: write the byte and advance the write pointer.
  - Push when full and no pop in the same cycle: drop the byte and set `key_overflow`.
  - Push when full and a pop in the same cycle: both proceed; count stays DEPTH; no overflow.
  - Push and pop on a non-full, non-empty FIFO in the same cycle: count unchanged.
- **Pop rule:** one pop per contiguous assertion of `clean_key_buffer`.
  - A `popped` flag is set on the cycle a pop occurs and cleared when `clean_key_buffer` is 0.
  - A pop occurs when `clean_key_buffer & keyboard_valid & ~popped`.
  - A request while the FIFO is empty does not set `popped`. The request stays pending and pops on the first cycle the FIFO is non-empty.
- `key_overflow` clears only on reset.

## Timing
- **Reset values:** FSM IDLE, FIFO empty, `pressed_key`=0, `keyboard_valid`=0, `key_overflow`=0, `frame_error`=0, `popped`=0. Synchronizer flops reset to 1 (the idle line level).
- **Push latency:** the `fall` strobe for the stop bit asserts on the 3rd CLK edge after the pin goes low. The push registers on the 4th edge. `keyboard_valid` and `pressed_key` are registered outputs and change on that 4th edge.
- **Pop latency:** the head advances on the clock edge ending the pop cycle. `keyboard_valid` deasserts on that same edge if the FIFO becomes empty.
- **Mid-frame reset:** any partial frame is discarded; no `frame_error`.
- **PS/2 clock:** 10–16.7 kHz, far below CLK, so at most one `fall` per frame bit.

## Configuration
- `PS2_BREAK_FILTER_EN` defined: a valid byte 8'hF0 is not pushed. It sets a `skip_next` flag, and the next valid byte is discarded while `skip_next` clears. Frame errors leave `skip_next` unchanged. Prefix 8'hE0 and all other bytes are pushed normally. Only make codes reach the CPU.
- Not defined: every valid byte, including F0 and the released-key code, is pushed; no `skip_next` logic is built.

## Test plan
- Send frame 0x1C (parity 0, stop 1); hold `clean_key_buffer` low → `keyboard_valid`=1 and `pressed_key`=0x1C, 4 CLK after the stop-bit falling edge.
- Send 0x1C then 0x32, and assert `clean_key_buffer` for 5 cycles → exactly one pop; `pressed_key`=0x32. Deassert, then reassert for 1 cycle → empty, `pressed_key`=0x00.
- Send 0x1C with parity bit 1 → `frame_error` pulses once; FIFO stays empty.
- Send only start plus 3 data bits, then idle TIMEOUT_CYCLES → `frame_error` pulse, FSM returns to IDLE. A subsequent full frame 0x29 is received correctly.
- Send DEPTH+1 frames (0x01..0x11) with no pops → `key_overflow`=1. Popping DEPTH times yields 0x01..0x10 in order.
- With `PS2_BREAK_FILTER_EN`, send 0x1C, 0xF0, 0x1C, 0xE0 → FIFO holds 0x1C, 0xE0 only. Without the macro → all four bytes are queued.
